// File: rtl/fpu_pkg.sv
// -----------------------------------------------------------------------------
// fpu_pkg
// Shared definitions for the FPU normalisation slice: default mantissa and
// exponent widths, the default per-cycle shift bound, the scheduler state
// enum and the status-flag bundle carried alongside each result.
// -----------------------------------------------------------------------------
package fpu_pkg;

  localparam int MANT_W_DEF = 25;
  localparam int EXP_W_DEF  = 8;
  localparam int STEP_DEF   = 4;

  typedef enum logic [1:0] {
    IDLE,
    NORM,
    DONE
  } state_t;

  typedef struct packed {
    logic zero;
    logic uflow;
    logic oflow;
  } status_t;

endpackage

// File: rtl/norm_step.sv
// -----------------------------------------------------------------------------
// norm_step
// Purely combinational single normalisation step. Given the working mantissa
// and exponent it produces the values for the next cycle, whether the pair
// is finished, and the status flags raised on that final step.
//
// Ports:
//   i_mant    working mantissa (bit MANT_W-1 carry, bit MANT_W-2 hidden one)
//   i_exp     working biased exponent
//   o_mant    mantissa after this step
//   o_exp     exponent after this step
//   o_done    pair is finished after this step
//   o_status  zero / uflow / oflow raised by this step
// -----------------------------------------------------------------------------
module norm_step
  import fpu_pkg::*;
#(
  parameter int MANT_W = MANT_W_DEF,
  parameter int EXP_W  = EXP_W_DEF,
  parameter int STEP   = STEP_DEF
) (
  input  logic [MANT_W-1:0] i_mant,
  input  logic [EXP_W-1:0]  i_exp,
  output logic [MANT_W-1:0] o_mant,
  output logic [EXP_W-1:0]  o_exp,
  output logic              o_done,
  output status_t           o_status
);

  int w_lz;
  int w_shift;

  // Leading-zero count below the carry bit, measured from the hidden-one
  // position. Scanning upward lets the highest set bit win; an all-zero
  // field leaves the count at MANT_W-1, which the zero case handles first.
  always_comb begin
    w_lz = MANT_W - 1;
    for (int i = 0; i <= MANT_W - 2; i++) begin
      if (i_mant[i]) begin
        w_lz = MANT_W - 2 - i;
      end
    end
  end

  // The shift is bounded by the per-cycle limit and by the exponent, so the
  // exponent can never be driven below zero by the subtraction.
  always_comb begin
    w_shift = w_lz;
    if (w_shift > STEP) begin
      w_shift = STEP;
    end
    if (w_shift > int'(i_exp)) begin
      w_shift = int'(i_exp);
    end
  end

  // Decision order matters: zero beats carry beats already-normalised beats
  // shifting. A carry with a saturated exponent keeps the mantissa as is and
  // reports overflow instead of wrapping the exponent.
  always_comb begin
    o_mant   = i_mant;
    o_exp    = i_exp;
    o_done   = 1'b0;
    o_status = '0;
    if (i_mant == '0) begin
      o_mant        = '0;
      o_exp         = '0;
      o_done        = 1'b1;
      o_status.zero = 1'b1;
    end else if (i_mant[MANT_W-1]) begin
      if (&i_exp) begin
        o_status.oflow = 1'b1;
      end else begin
        o_mant = i_mant >> 1;
        o_exp  = i_exp + EXP_W'(1);
      end
      o_done = 1'b1;
    end else if (i_mant[MANT_W-2]) begin
      o_done = 1'b1;
    end else begin
      o_mant = i_mant << w_shift;
      o_exp  = i_exp - EXP_W'(w_shift);
      if (o_mant[MANT_W-2]) begin
        o_done = 1'b1;
      end else if (o_exp == '0) begin
        o_done         = 1'b1;
        o_status.uflow = 1'b1;
      end
    end
  end

endmodule

// File: rtl/norm_scheduler.sv
// -----------------------------------------------------------------------------
// norm_scheduler
// Shared multi-cycle normalisation engine. Arbitrates round-robin between the
// add/sub path (requester 0) and the multiply path (requester 1), accepts one
// mantissa/exponent pair at a time, normalises it at most STEP positions per
// cycle and holds the result on a valid/ready output until consumed.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   i_reqN_valid / o_reqN_ready requester handshake (ready only in IDLE)
//   i_reqN_mant / i_reqN_exp    unnormalised pair from requester N
//   o_out_valid / i_out_ready   result handshake
//   o_out_mant / o_out_exp      normalised mantissa and adjusted exponent
//   o_out_src                   requester index of the held result
//   o_out_zero/uflow/oflow      status flags of the held result
// -----------------------------------------------------------------------------
module norm_scheduler
  import fpu_pkg::*;
#(
  parameter int MANT_W = MANT_W_DEF,
  parameter int EXP_W  = EXP_W_DEF,
  parameter int STEP   = STEP_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req0_valid,
  input  logic              i_req1_valid,
  output logic              o_req0_ready,
  output logic              o_req1_ready,
  input  logic [MANT_W-1:0] i_req0_mant,
  input  logic [MANT_W-1:0] i_req1_mant,
  input  logic [EXP_W-1:0]  i_req0_exp,
  input  logic [EXP_W-1:0]  i_req1_exp,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [MANT_W-1:0] o_out_mant,
  output logic [EXP_W-1:0]  o_out_exp,
  output logic              o_out_src,
  output logic              o_out_zero,
  output logic              o_out_uflow,
  output logic              o_out_oflow
);

  state_t            r_state;
  state_t            w_nextState;
  logic              r_rrPrio;
  logic [MANT_W-1:0] r_mant;
  logic [EXP_W-1:0]  r_exp;
  logic              r_src;
  status_t           r_status;

  logic              w_grant0;
  logic              w_grant1;
  logic              w_accept;

  logic [MANT_W-1:0] w_stepMant;
  logic [EXP_W-1:0]  w_stepExp;
  logic              w_stepDone;
  status_t           w_stepStatus;

  norm_step #(
    .MANT_W (MANT_W),
    .EXP_W  (EXP_W),
    .STEP   (STEP)
  ) u_normStep (
    .i_mant   (r_mant),
    .i_exp    (r_exp),
    .o_mant   (w_stepMant),
    .o_exp    (w_stepExp),
    .o_done   (w_stepDone),
    .o_status (w_stepStatus)
  );

  // Round-robin grant: a lone requester always wins; with both valid the
  // priority bit picks the one that was not served last.
  always_comb begin
    w_grant0 = i_req0_valid && (!i_req1_valid || !r_rrPrio);
    w_grant1 = i_req1_valid && (!i_req0_valid ||  r_rrPrio);
    w_accept = (r_state == IDLE) && (w_grant0 || w_grant1);
  end

  // State register; reset abandons any in-flight pair immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_accept)    w_nextState = NORM;
      NORM:    if (w_stepDone)  w_nextState = DONE;
      DONE:    if (i_out_ready) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Output decode: ready is only ever offered while idle, valid only in DONE.
  always_comb begin
    o_req0_ready = (r_state == IDLE) && w_grant0;
    o_req1_ready = (r_state == IDLE) && w_grant1;
    o_out_valid  = (r_state == DONE);
  end

  // Working registers double as the output registers. They load on accept,
  // advance once per NORM cycle and freeze in DONE; the flags are dropped on
  // the transfer edge so a stale flag never accompanies the next result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mant   <= '0;
      r_exp    <= '0;
      r_src    <= 1'b0;
      r_status <= '0;
      r_rrPrio <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_mant   <= w_grant1 ? i_req1_mant : i_req0_mant;
            r_exp    <= w_grant1 ? i_req1_exp  : i_req0_exp;
            r_src    <= w_grant1;
            r_status <= '0;
            r_rrPrio <= w_grant0;
          end
        end
        NORM: begin
          r_mant   <= w_stepMant;
          r_exp    <= w_stepExp;
          r_status <= w_stepStatus;
        end
        DONE: begin
          if (i_out_ready) begin
            r_status <= '0;
          end
        end
        default: begin
          r_status <= '0;
        end
      endcase
    end
  end

  assign o_out_mant  = r_mant;
  assign o_out_exp   = r_exp;
  assign o_out_src   = r_src;
  assign o_out_zero  = r_status.zero;
  assign o_out_uflow = r_status.uflow;
  assign o_out_oflow = r_status.oflow;

endmodule
